// File: rtl/odd_even_sort_pkg.sv
// huffman_sort_pkg: shared definitions for the odd-even transposition sorter.
//   sort_idx_w(n) : width of a symbol index, max(1, clog2(n))
//   sort_state_e  : controller states ST_IDLE / ST_SORT / ST_DONE
//   ORDER_ASC / ORDER_DESC : values for the DESCEND parameter
package huffman_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } sort_state_e;

  localparam int unsigned ORDER_ASC  = 0;
  localparam int unsigned ORDER_DESC = 1;

  function automatic int unsigned sort_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/odd_even_sort_cmp_swap.sv
// sort_cmp_swap: one combinational compare-exchange cell.
//   a_* is the lower position, b_* the upper position of the pair.
//   Outputs carry the ordered pair; weight and index move together.
//   A swap happens only on strict inequality, so equal weights keep order.
//   swapped_o exists only when SORT_EARLY_EXIT_EN is defined.
module sort_cmp_swap
  import huffman_sort_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned IW      = 2,
  parameter int unsigned DESCEND = ORDER_ASC
) (
  input  logic [W-1:0]  a_w_i,
  input  logic [W-1:0]  b_w_i,
  input  logic [IW-1:0] a_idx_i,
  input  logic [IW-1:0] b_idx_i,
  output logic [W-1:0]  a_w_o,
  output logic [W-1:0]  b_w_o,
  output logic [IW-1:0] a_idx_o,
  output logic [IW-1:0] b_idx_o
`ifdef SORT_EARLY_EXIT_EN
  ,output logic         swapped_o
`endif
);

  localparam bit DESC = (DESCEND == ORDER_DESC);

  logic swap;

  always_comb begin
    swap    = DESC ? (a_w_i < b_w_i) : (a_w_i > b_w_i);
    a_w_o   = swap ? b_w_i   : a_w_i;
    b_w_o   = swap ? a_w_i   : b_w_i;
    a_idx_o = swap ? b_idx_i : a_idx_i;
    b_idx_o = swap ? a_idx_i : b_idx_i;
  end

`ifdef SORT_EARLY_EXIT_EN
  assign swapped_o = swap;
`endif

endmodule

// File: rtl/odd_even_sort.sv
// odd_even_sort: sorts N W-bit weights (with original indices) using an
// odd-even transposition network, one compare-exchange phase per clock.
//   CLK, RST (sync, active high)
//   IN_VALID/IN_READY/IN_WEIGHTS   : load handshake, weight i at [i*W +: W]
//   OUT_VALID/OUT_READY            : unload handshake
//   SORT_RESULT/SORT_INDEX         : sorted weights / original indices
//   BUSY                           : high while sorting
// Optional macro SORT_EARLY_EXIT_EN: finish after two consecutive
// swap-free phases instead of always running N phases.
module odd_even_sort
  import huffman_sort_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned DESCEND = ORDER_ASC,
  localparam int unsigned IW     = sort_idx_w(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [N*W-1:0]  IN_WEIGHTS,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [N*W-1:0]  SORT_RESULT,
  output logic [N*IW-1:0] SORT_INDEX,
  output logic          BUSY
);

  localparam int unsigned NE = N / 2;        // even-phase pairs
  localparam int unsigned NO = (N - 1) / 2;  // odd-phase pairs
  localparam int unsigned PW = $clog2(N) + 1;
  localparam logic [PW-1:0] LAST_P = PW'(N - 1);

  sort_state_e   state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [W-1:0]  w_q [N];
  logic [W-1:0]  w_d [N];
  logic [IW-1:0] idx_q [N];
  logic [IW-1:0] idx_d [N];

  // Both parities are evaluated every cycle; p_q[0] picks the one applied.
  logic [W-1:0]  ev_w [N];
  logic [IW-1:0] ev_idx [N];
  logic [W-1:0]  od_w [N];
  logic [IW-1:0] od_idx [N];

`ifdef SORT_EARLY_EXIT_EN
  localparam int unsigned NOA = (NO == 0) ? 1 : NO;
  logic [NE-1:0]  ev_sw;
  logic [NOA-1:0] od_sw;
  logic           ph_swap;
  logic           quiet_q, quiet_d;  // previous phase performed no swap
`endif

  for (genvar k = 0; k < NE; k++) begin : g_even
    sort_cmp_swap #(.W(W), .IW(IW), .DESCEND(DESCEND)) u_cell (
      .a_w_i   (w_q[2*k]),
      .b_w_i   (w_q[2*k+1]),
      .a_idx_i (idx_q[2*k]),
      .b_idx_i (idx_q[2*k+1]),
      .a_w_o   (ev_w[2*k]),
      .b_w_o   (ev_w[2*k+1]),
      .a_idx_o (ev_idx[2*k]),
      .b_idx_o (ev_idx[2*k+1])
`ifdef SORT_EARLY_EXIT_EN
      ,.swapped_o(ev_sw[k])
`endif
    );
  end

  if (N % 2 == 1) begin : g_even_tail
    assign ev_w[N-1]   = w_q[N-1];
    assign ev_idx[N-1] = idx_q[N-1];
  end

  assign od_w[0]   = w_q[0];
  assign od_idx[0] = idx_q[0];

  for (genvar k = 0; k < NO; k++) begin : g_odd
    sort_cmp_swap #(.W(W), .IW(IW), .DESCEND(DESCEND)) u_cell (
      .a_w_i   (w_q[2*k+1]),
      .b_w_i   (w_q[2*k+2]),
      .a_idx_i (idx_q[2*k+1]),
      .b_idx_i (idx_q[2*k+2]),
      .a_w_o   (od_w[2*k+1]),
      .b_w_o   (od_w[2*k+2]),
      .a_idx_o (od_idx[2*k+1]),
      .b_idx_o (od_idx[2*k+2])
`ifdef SORT_EARLY_EXIT_EN
      ,.swapped_o(od_sw[k])
`endif
    );
  end

  if (N % 2 == 0) begin : g_odd_tail
    assign od_w[N-1]   = w_q[N-1];
    assign od_idx[N-1] = idx_q[N-1];
  end

`ifdef SORT_EARLY_EXIT_EN
  if (NO == 0) begin : g_odd_sw_tie
    assign od_sw = '0;
  end
  assign ph_swap = p_q[0] ? (|od_sw) : (|ev_sw);
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    w_d     = w_q;
    idx_d   = idx_q;
`ifdef SORT_EARLY_EXIT_EN
    quiet_d = quiet_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          for (int unsigned i = 0; i < N; i++) begin
            w_d[i]   = IN_WEIGHTS[i*W +: W];
            idx_d[i] = IW'(i);
          end
          p_d     = '0;
          state_d = ST_SORT;
`ifdef SORT_EARLY_EXIT_EN
          quiet_d = 1'b0;
`endif
        end
      end
      ST_SORT: begin
        for (int unsigned i = 0; i < N; i++) begin
          w_d[i]   = p_q[0] ? od_w[i]   : ev_w[i];
          idx_d[i] = p_q[0] ? od_idx[i] : ev_idx[i];
        end
        p_d = p_q + 1'b1;
        if (p_q == LAST_P) state_d = ST_DONE;
`ifdef SORT_EARLY_EXIT_EN
        quiet_d = ~ph_swap;
        if ((p_q != '0) && quiet_q && !ph_swap) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        w_q[i]   <= '0;
        idx_q[i] <= '0;
      end
`ifdef SORT_EARLY_EXIT_EN
      quiet_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
`ifdef SORT_EARLY_EXIT_EN
      quiet_q <= quiet_d;
`endif
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      SORT_RESULT[i*W +: W]  = w_q[i];
      SORT_INDEX[i*IW +: IW] = idx_q[i];
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign BUSY      = (state_q == ST_SORT);

endmodule

// File: tb/tb_odd_even_sort.sv
// Bench for odd_even_sort: an ascending and a descending instance (N=4, W=8)
// share the load stimulus; results are compared with hand-derived tables and
// with a rank-based stable-sort model for random vectors.
module tb_odd_even_sort;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam logic [N*IW-1:0] IDENT = 8'b11_10_01_00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, ordy_a, ordy_d;
  logic [N*W-1:0] in_w;
  logic           ir_a, ov_a, busy_a, ir_d, ov_d, busy_d;
  logic [N*W-1:0] res_a, res_d;
  logic [N*IW-1:0] idx_a, idx_d;

  odd_even_sort #(.N(N), .W(W), .DESCEND(0)) u_asc (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ir_a),
    .IN_WEIGHTS(in_w), .OUT_VALID(ov_a), .OUT_READY(ordy_a),
    .SORT_RESULT(res_a), .SORT_INDEX(idx_a), .BUSY(busy_a));

  odd_even_sort #(.N(N), .W(W), .DESCEND(1)) u_desc (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ir_d),
    .IN_WEIGHTS(in_w), .OUT_VALID(ov_d), .OUT_READY(ordy_d),
    .SORT_RESULT(res_d), .SORT_INDEX(idx_d), .BUSY(busy_d));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pw(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [N*IW-1:0] pi(input logic [1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Stable sort by rank: final position = number of elements that must precede.
  task automatic model(input logic [N*W-1:0] win, input bit desc,
                       output logic [N*W-1:0] ow, output logic [N*IW-1:0] oi);
    int rank;
    logic [W-1:0] wi, wj;
    ow = '0;
    oi = '0;
    for (int i = 0; i < N; i++) begin
      rank = 0;
      wi = win[i*W +: W];
      for (int j = 0; j < N; j++) begin
        wj = win[j*W +: W];
        if ((desc ? (wj > wi) : (wj < wi)) || (wj == wi && j < i)) rank++;
      end
      ow[rank*W +: W]   = wi;
      oi[rank*IW +: IW] = IW'(i);
    end
  endtask

  // Called in cycle c+1 after a load edge; returns latency (k => cycle c+k).
  task automatic wait_done(input string name, output int lat_a, output int lat_d);
    int bad;
    lat_a = 0;
    lat_d = 0;
    bad   = 0;
    for (int k = 1; k <= 100; k++) begin
      if (lat_a == 0 && ov_a) lat_a = k;
      if (lat_d == 0 && ov_d) lat_d = k;
      if (lat_a == 0 && busy_a !== 1'b1) bad++;
      if (lat_d == 0 && busy_d !== 1'b1) bad++;
      if (lat_a != 0 && lat_d != 0) break;
      step();
    end
    check({name, " timeout"}, 64'(lat_a != 0 && lat_d != 0), 64'd1);
    check({name, " busy"}, 64'(bad), 64'd0);
  endtask

  task automatic check_lat(input string name, input int lat, input logic [N*IW-1:0] ei);
`ifdef SORT_EARLY_EXIT_EN
    if (ei == IDENT) check(name, 64'(lat), 64'd3);
    else check(name, 64'(lat >= 4 && lat <= N + 1), 64'd1);
`else
    check(name, 64'(lat), 64'(N + 1));
`endif
  endtask

  task automatic run_vec(input string name, input logic [N*W-1:0] win,
                         input logic [N*W-1:0] aw, input logic [N*IW-1:0] ai,
                         input logic [N*W-1:0] dw, input logic [N*IW-1:0] di);
    int la, ld;
    check({name, " in_ready"}, 64'({ir_a, ir_d}), 64'd3);
    in_w = win;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_w = $urandom;
    wait_done(name, la, ld);
    check_lat({name, " lat_asc"}, la, ai);
    check_lat({name, " lat_desc"}, ld, di);
    check({name, " res_asc"}, 64'(res_a), 64'(aw));
    check({name, " idx_asc"}, 64'(idx_a), 64'(ai));
    check({name, " res_desc"}, 64'(res_d), 64'(dw));
    check({name, " idx_desc"}, 64'(idx_d), 64'(di));
    ordy_a = 1'b1;
    ordy_d = 1'b1;
    step();
    ordy_a = 1'b0;
    ordy_d = 1'b0;
    check({name, " unload"}, 64'({ov_a, ov_d, ir_a, ir_d}), 64'b0011);
  endtask

  typedef struct {
    string           name;
    logic [N*W-1:0]  w;
    logic [N*W-1:0]  aw;
    logic [N*IW-1:0] ai;
    logic [N*W-1:0]  dw;
    logic [N*IW-1:0] di;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [N*W-1:0]  mw_a, mw_d, rw;
    logic [N*IW-1:0] mi_a, mi_d;
    int la, ld, hit;

    tbl[0] = '{"spec",      pw(8'hC5, 8'h81, 8'hFE, 8'h3A), pw(8'h3A, 8'h81, 8'hC5, 8'hFE), pi(3, 1, 0, 2),
               pw(8'hFE, 8'hC5, 8'h81, 8'h3A), pi(2, 0, 1, 3)};
    tbl[1] = '{"ties",      pw(8'h10, 8'h10, 8'h05, 8'h10), pw(8'h05, 8'h10, 8'h10, 8'h10), pi(2, 0, 1, 3),
               pw(8'h10, 8'h10, 8'h10, 8'h05), pi(0, 1, 3, 2)};
    tbl[2] = '{"presorted", pw(8'h01, 8'h02, 8'h03, 8'h04), pw(8'h01, 8'h02, 8'h03, 8'h04), pi(0, 1, 2, 3),
               pw(8'h04, 8'h03, 8'h02, 8'h01), pi(3, 2, 1, 0)};
    tbl[3] = '{"descvec",   pw(8'h3A, 8'hC5, 8'h81, 8'hFE), pw(8'h3A, 8'h81, 8'hC5, 8'hFE), pi(0, 2, 1, 3),
               pw(8'hFE, 8'hC5, 8'h81, 8'h3A), pi(3, 1, 2, 0)};
    tbl[4] = '{"zeros",     pw(8'h00, 8'h00, 8'h00, 8'h00), pw(8'h00, 8'h00, 8'h00, 8'h00), pi(0, 1, 2, 3),
               pw(8'h00, 8'h00, 8'h00, 8'h00), pi(0, 1, 2, 3)};
    tbl[5] = '{"extremes",  pw(8'hFF, 8'h00, 8'hFF, 8'h00), pw(8'h00, 8'h00, 8'hFF, 8'hFF), pi(1, 3, 0, 2),
               pw(8'hFF, 8'hFF, 8'h00, 8'h00), pi(0, 2, 1, 3)};
    tbl[6] = '{"reverse",   pw(8'h04, 8'h03, 8'h02, 8'h01), pw(8'h01, 8'h02, 8'h03, 8'h04), pi(3, 2, 1, 0),
               pw(8'h04, 8'h03, 8'h02, 8'h01), pi(0, 1, 2, 3)};

    rst = 1'b1;
    in_valid = 1'b0;
    in_w = '0;
    ordy_a = 1'b0;
    ordy_d = 1'b0;
    step();
    step();
    check("reset flags_asc", 64'({ir_a, ov_a, busy_a}), 64'b100);
    check("reset flags_desc", 64'({ir_d, ov_d, busy_d}), 64'b100);
    check("reset data", 64'({res_a, idx_a}), 64'd0);
    rst = 1'b0;
    step();

    foreach (tbl[t]) run_vec(tbl[t].name, tbl[t].w, tbl[t].aw, tbl[t].ai, tbl[t].dw, tbl[t].di);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++)
        rw[i*W +: W] = (r % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      model(rw, 1'b0, mw_a, mi_a);
      model(rw, 1'b1, mw_d, mi_d);
      run_vec($sformatf("rand%0d", r), rw, mw_a, mi_a, mw_d, mi_d);
    end

    // Backpressure: outputs hold and no load while stalled in DONE.
    in_w = tbl[0].w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done("stall", la, ld);
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid;
      in_w = $urandom;
      step();
      check($sformatf("stall%0d asc", c), 64'({ov_a, ir_a, res_a, idx_a}), 64'({2'b10, tbl[0].aw, tbl[0].ai}));
      check($sformatf("stall%0d desc", c), 64'({ov_d, ir_d, res_d, idx_d}), 64'({2'b10, tbl[0].dw, tbl[0].di}));
    end
    in_valid = 1'b0;
    ordy_a = 1'b1;
    ordy_d = 1'b1;
    step();
    ordy_a = 1'b0;
    ordy_d = 1'b0;
    check("stall release", 64'({ov_a, ir_a, busy_a, ov_d, ir_d, busy_d}), 64'b010010);

    // Reset while phase 2 is executing.
    in_w = tbl[6].w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset flags", 64'({ir_a, ov_a, busy_a, ir_d, ov_d, busy_d}), 64'b100100);
    check("midreset data", 64'({res_a, idx_a, res_d, idx_d}), 64'd0);
    run_vec("after_reset", tbl[0].w, tbl[0].aw, tbl[0].ai, tbl[0].dw, tbl[0].di);

    // OUT_READY held high before OUT_VALID: DONE lasts exactly one cycle.
    ordy_a = 1'b1;
    ordy_d = 1'b1;
    in_w = tbl[3].w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    hit = 0;
    for (int k = 1; k <= 100; k++) begin
      if (ov_a) begin
        hit = k;
        check("early_ready res", 64'({res_a, idx_a}), 64'({tbl[3].aw, tbl[3].ai}));
        step();
        check("early_ready next", 64'({ov_a, ir_a}), 64'b01);
        break;
      end
      step();
    end
    check("early_ready seen", 64'(hit != 0), 64'd1);
    step();
    step();
    ordy_a = 1'b0;
    ordy_d = 1'b0;
    check("final idle", 64'({ir_a, ir_d}), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
